mcycle_ctrl: RTL and testbench
==============================

# mcycle_ctrl

Multi-cycle MIPS control unit: a Moore state machine that sequences every instruction through fetch, decode, execute, memory and write-back. It sits directly upstream of the datapath buffer registers (DR, A, B, ALUOut), the PC, the IR and the register file. It drives the write enables and the mux selects that decide what those registers capture each cycle. DR, A, B and ALUOut load every cycle without an enable, so this block alone determines which captured value is consumed.

## Interface
Parameters:
- `RESET_STATE`, default 4'd0 (S_IF). State entered on reset.

Ports:
- `clk`  in  1  system clock; all state changes occur on its rising edge.
- `rst`  in  1  reset. **Synchronous, active-high.**
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ack`  in  1  memory completed the requested access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_wr`  out  1  qualifies `mem_req` as a write.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_wr`  out  1  IR load.
- `pc_wr`  out  1  PC load (final, zero-qualified).
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B input: 00 = B, 01 = 4, 10 = immediate extended, 11 = sign-extended immediate << 2.
- `ext_zero`  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- `alu_ctrl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `reg_wr`  out  1  register file write.
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = DR.
- `illegal`  out  1  one-cycle pulse in S_ID on an unsupported op or funct.

## Operation
- Supported opcodes:
  - R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000, ori 001101.
- States and transitions:
  - S_IF: `mem_req`=1, `iord`=0, PC+4 computed (`alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00). When `mem_ack`=1, assert `ir_wr` and `pc_wr` in that cycle and go to S_ID; otherwise hold in S_IF.
  - S_ID: branch target computed (`alu_src_a`=0, `alu_src_b`=11, add); A and B capture the register file outputs. Dispatch:
    - lw/sw → S_MADR
    - R-type → S_EXE
    - beq → S_BEQ
    - j → S_JMP
    - addi/ori → S_IEXE
    - unsupported → pulse `illegal`, go to S_IF
  - S_MADR: `alu_src_a`=1, `alu_src_b`=10, add. Go to S_MRD for lw, S_MWR for sw.
  - S_MRD: `mem_req`=1, `iord`=1. Wait for `mem_ack`, then go to S_MWB; DR captures the read data.
  - S_MWB: `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=1. Go to S_IF.
  - S_MWR: `mem_req`=1, `mem_wr`=1, `iord`=1. Wait for `mem_ack`, then go to S_IF.
  - S_EXE: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct. Go to S_RWB.
  - S_RWB: `reg_wr`=1, `reg_dst`=1, `mem_to_reg`=0. Go to S_IF.
  - S_BEQ: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `pc_wr`=`zero`. Go to S_IF.
  - S_JMP: `pc_src`=10, `pc_wr`=1. Go to S_IF.
  - S_IEXE: `alu_src_a`=1, `alu_src_b`=10. addi: add with `ext_zero`=0. ori: or with `ext_zero`=1. Go to S_IWB.
  - S_IWB: `reg_wr`=1, `reg_dst`=0, `mem_to_reg`=0. Go to S_IF.
- Any state code not listed above returns to S_IF.
- Every output not listed for a state is 0.

## Timing
- Reset: `rst` high at a rising edge loads S_IF. While `rst`=1, all outputs are forced to 0; no write enable or `mem_req` may assert.
- Reset mid-instruction (for example in S_MWR before `mem_ack`): the instruction is abandoned and no `reg_wr` or `pc_wr` follows.
- All outputs are a function of state only, except:
  - `pc_wr` in S_BEQ, which depends on `zero`;
  - `ir_wr`/`pc_wr` in S_IF, which depend on `mem_ack`.
- `mem_ack` arriving in any state that is not requesting memory is ignored.
- `mem_req` stays high continuously until `mem_ack`. `mem_ack` in the first request cycle completes the access in that same cycle.
- Minimum cycle counts with `mem_ack` tied to 1:
  - lw: 5 cycles
  - R-type, addi, ori, sw: 4 cycles
  - beq, j: 3 cycles
- Each `mem_ack` wait cycle adds exactly one cycle.

## Structure
- Shared package `mcycle_pkg` holds:
  - state enum (4-bit, S_IF = 0 … S_IWB = 11);
  - opcode and funct constants;
  - `alu_ctrl` codes;
  - `alu_src_b` and `pc_src` codes.
- Sub-module `alu_dec` is combinational: it maps (aluop class, funct) to `alu_ctrl` and flags an unsupported funct. The FSM lives in `mcycle_ctrl` and consists of a state register plus next-state and output logic.

## Test plan
- Reset: hold `rst`=1 for 3 cycles while `mem_ack`=1 → all outputs 0; the first cycle after release is S_IF with `mem_req`=1 and `ir_wr`=`pc_wr`=1.
- R-type add (op 000000, funct 100000), `mem_ack`=1 → exactly 4 cycles; `alu_ctrl`=010 in S_EXE; `reg_wr`=1 with `reg_dst`=1 only in cycle 4.
- lw (100011) with `mem_ack` delayed 2 cycles in S_MRD → 7 cycles total; `iord`=1 throughout S_MRD; `reg_wr`=1 with `mem_to_reg`=1 in the last cycle.
- beq (000100): `zero`=1 → `pc_wr`=1 with `pc_src`=01 in cycle 3. `zero`=0 → `pc_wr`=0 and the next cycle is S_IF.
- ori (001101) → `ext_zero`=1 and `alu_ctrl`=001 in S_IEXE. Illegal op 111111 → `illegal` pulses in S_ID and returns to S_IF, with no `reg_wr` and no `mem_wr`.
- sw (101011) with `rst` asserted during S_MWR wait → state S_IF next cycle; `mem_wr` never accompanied by `mem_ack`; no `pc_wr` from the aborted instruction.

Source files
------------

// File: rtl/mcycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_pkg
// Description : Shared types and encodings for the multi-cycle MIPS control.
// Revision    : 1.0 - initial release
// ============================================================================
package mcycle_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_EXE  = 4'd6,
        S_RWB  = 4'd7,
        S_BEQ  = 4'd8,
        S_JMP  = 4'd9,
        S_IEXE = 4'd10,
        S_IWB  = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2,
        ALUOP_OR    = 2'd3
    } aluop_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_BRANCH = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_ctrl;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == c_OP_RTYPE) || (op == c_OP_LW) || (op == c_OP_SW) ||
               (op == c_OP_BEQ) || (op == c_OP_J) || (op == c_OP_ADDI) ||
               (op == c_OP_ORI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_dec
// Description : Maps ALU operation class and funct field to the ALU control.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_dec
    import mcycle_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_bad_o
);

    logic [2:0] w_fn_ctrl;

    // funct is decoded regardless of class so the decode state can flag it early
    always_comb begin
        w_fn_ctrl   = c_ALU_ADD;
        funct_bad_o = 1'b0;
        case (funct_i)
            c_FN_ADD: w_fn_ctrl = c_ALU_ADD;
            c_FN_SUB: w_fn_ctrl = c_ALU_SUB;
            c_FN_AND: w_fn_ctrl = c_ALU_AND;
            c_FN_OR:  w_fn_ctrl = c_ALU_OR;
            c_FN_SLT: w_fn_ctrl = c_ALU_SLT;
            default:  funct_bad_o = 1'b1;
        endcase
    end

    always_comb begin
        alu_ctrl_o = c_ALU_ADD;
        case (aluop_i)
            ALUOP_SUB:   alu_ctrl_o = c_ALU_SUB;
            ALUOP_FUNCT: alu_ctrl_o = w_fn_ctrl;
            ALUOP_OR:    alu_ctrl_o = c_ALU_OR;
            default:     alu_ctrl_o = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mcycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_ctrl
// Description : Multi-cycle MIPS control FSM (fetch/decode/execute/mem/WB).
// Revision    : 1.0 - initial release
// ============================================================================
module mcycle_ctrl
    import mcycle_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_ctrl,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    state_t     state_q, state_d;
    aluop_t     w_aluop;
    logic [2:0] w_alu_ctrl;
    logic       w_funct_bad;
    logic       w_legal;
    ctrl_t      w_ctrl;

    alu_dec u_alu_dec (
        .aluop_i     (w_aluop),
        .funct_i     (funct),
        .alu_ctrl_o  (w_alu_ctrl),
        .funct_bad_o (w_funct_bad)
    );

    assign w_legal = op_supported(op) && !((op == c_OP_RTYPE) && w_funct_bad);

    always_ff @(posedge clk) begin
        if (rst) state_q <= state_t'(RESET_STATE);
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = mem_ack ? S_ID : S_IF;
            S_ID: begin
                if (!w_legal)                                state_d = S_IF;
                else if (op == c_OP_LW || op == c_OP_SW)     state_d = S_MADR;
                else if (op == c_OP_RTYPE)                   state_d = S_EXE;
                else if (op == c_OP_BEQ)                     state_d = S_BEQ;
                else if (op == c_OP_J)                       state_d = S_JMP;
                else                                         state_d = S_IEXE;
            end
            S_MADR: state_d = (op == c_OP_SW) ? S_MWR : S_MRD;
            S_MRD:  state_d = mem_ack ? S_MWB : S_MRD;
            S_MWR:  state_d = mem_ack ? S_IF : S_MWR;
            S_EXE:  state_d = S_RWB;
            S_IEXE: state_d = S_IWB;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        w_aluop = ALUOP_ADD;
        case (state_q)
            S_EXE:   w_aluop = ALUOP_FUNCT;
            S_BEQ:   w_aluop = ALUOP_SUB;
            S_IEXE:  w_aluop = (op == c_OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            default: w_aluop = ALUOP_ADD;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        case (state_q)
            S_IF: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_FOUR;
                w_ctrl.alu_ctrl  = w_alu_ctrl;
                w_ctrl.pc_src    = c_PCSRC_ALU;
                w_ctrl.ir_wr     = mem_ack;
                w_ctrl.pc_wr     = mem_ack;
            end
            S_ID: begin
                w_ctrl.alu_src_b = c_SRCB_BRANCH;
                w_ctrl.alu_ctrl  = w_alu_ctrl;
                w_ctrl.illegal   = !w_legal;
            end
            S_MADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_IMM;
                w_ctrl.alu_ctrl  = w_alu_ctrl;
            end
            S_MRD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            S_MWB: begin
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.mem_wr  = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            S_EXE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_B;
                w_ctrl.alu_ctrl  = w_alu_ctrl;
            end
            S_RWB: begin
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.reg_dst = 1'b1;
            end
            S_BEQ: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_B;
                w_ctrl.alu_ctrl  = w_alu_ctrl;
                w_ctrl.pc_src    = c_PCSRC_ALUOUT;
                w_ctrl.pc_wr     = zero;
            end
            S_JMP: begin
                w_ctrl.pc_src = c_PCSRC_JUMP;
                w_ctrl.pc_wr  = 1'b1;
            end
            S_IEXE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_IMM;
                w_ctrl.alu_ctrl  = w_alu_ctrl;
                w_ctrl.ext_zero  = (op == c_OP_ORI);
            end
            S_IWB:   w_ctrl.reg_wr = 1'b1;
            default: w_ctrl = '0;
        endcase
        // Reset silences every enable immediately, not just from the next edge
        if (rst) w_ctrl = '0;
    end

    assign mem_req    = w_ctrl.mem_req;
    assign mem_wr     = w_ctrl.mem_wr;
    assign iord       = w_ctrl.iord;
    assign ir_wr      = w_ctrl.ir_wr;
    assign pc_wr      = w_ctrl.pc_wr;
    assign pc_src     = w_ctrl.pc_src;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign ext_zero   = w_ctrl.ext_zero;
    assign alu_ctrl   = w_ctrl.alu_ctrl;
    assign reg_wr     = w_ctrl.reg_wr;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign illegal    = w_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcycle_ctrl
// Description : Self-checking bench for mcycle_ctrl with an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_ctrl;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_wr, iord, ir_wr, pc_wr, alu_src_a, ext_zero;
    logic       reg_wr, reg_dst, mem_to_reg, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctrl;
    outs_t      dut_o;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mcycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .alu_ctrl(alu_ctrl), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal)
    );

    assign dut_o = {mem_req, mem_wr, iord, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
                    ext_zero, alu_ctrl, reg_wr, reg_dst, mem_to_reg, illegal};

    // ---------------- reference model: instruction semantics ----------------
    function automatic logic legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
                              (f == 6'b100101) || (f == 6'b101010);
            6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001101: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] fn_ctrl(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic outs_t e_fetch(input logic ack);
        outs_t e = '0;
        e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
        e.ir_wr = ack; e.pc_wr = ack;
        return e;
    endfunction

    function automatic outs_t e_decode(input logic [5:0] o, input logic [5:0] f);
        outs_t e = '0;
        e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010; e.illegal = !legal(o, f);
        return e;
    endfunction

    function automatic outs_t e_madr();
        outs_t e = '0;
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010;
        return e;
    endfunction

    function automatic outs_t e_mem(input logic wr);
        outs_t e = '0;
        e.mem_req = 1'b1; e.iord = 1'b1; e.mem_wr = wr;
        return e;
    endfunction

    // One cycle: drive mem_ack, compare mid-cycle, then advance past the edge.
    task automatic step(input logic ack, input outs_t exp, input string tag);
        mem_ack = ack;
        @(negedge clk);
        checks++;
        assert (dut_o === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, dut_o, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wf, input int wd, input string tag);
        outs_t e;
        op = o; funct = f; zero = z;
        for (int i = 0; i <= wf; i++) step(i == wf, e_fetch(i == wf), {tag, ":IF"});
        step(1'($urandom_range(0, 1)), e_decode(o, f), {tag, ":ID"});
        if (!legal(o, f)) return;
        case (o)
            6'b000000: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_ctrl = fn_ctrl(f);
                step(1'($urandom_range(0, 1)), e, {tag, ":EXE"});
                e = '0; e.reg_wr = 1'b1; e.reg_dst = 1'b1;
                step(1'($urandom_range(0, 1)), e, {tag, ":RWB"});
            end
            6'b100011: begin
                step(1'($urandom_range(0, 1)), e_madr(), {tag, ":MADR"});
                for (int i = 0; i <= wd; i++) step(i == wd, e_mem(1'b0), {tag, ":MRD"});
                e = '0; e.reg_wr = 1'b1; e.mem_to_reg = 1'b1;
                step(1'($urandom_range(0, 1)), e, {tag, ":MWB"});
            end
            6'b101011: begin
                step(1'($urandom_range(0, 1)), e_madr(), {tag, ":MADR"});
                for (int i = 0; i <= wd; i++) step(i == wd, e_mem(1'b1), {tag, ":MWR"});
            end
            6'b000100: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_wr = z;
                step(1'($urandom_range(0, 1)), e, {tag, ":BEQ"});
            end
            6'b000010: begin
                e = '0; e.pc_src = 2'b10; e.pc_wr = 1'b1;
                step(1'($urandom_range(0, 1)), e, {tag, ":JMP"});
            end
            default: begin
                e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                e.alu_ctrl = (o == 6'b001101) ? 3'b001 : 3'b010;
                e.ext_zero = (o == 6'b001101);
                step(1'($urandom_range(0, 1)), e, {tag, ":IEXE"});
                e = '0; e.reg_wr = 1'b1;
                step(1'($urandom_range(0, 1)), e, {tag, ":IWB"});
            end
        endcase
    endtask

    logic [5:0] ops [8]   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000010, 6'b001000, 6'b001101, 6'b111111};
    logic [5:0] fns [5]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] ro, rf;
        rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ack = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, '0, "reset_hold");
        rst = 1'b0;

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "add");
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, "lw_wait2");
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_not");
        run_instr(6'b001101, 6'b000000, 1'b0, 0, 0, "ori");
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal_op");
        run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, "illegal_fn");
        run_instr(6'b001000, 6'b000000, 1'b0, 1, 0, "addi_fwait");
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "j");
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 1, "sw_wait1");

        // sw abandoned by reset while waiting on the write acknowledge
        op = 6'b101011; funct = '0; zero = 1'b0;
        step(1'b1, e_fetch(1'b1), "abort:IF");
        step(1'b0, e_decode(6'b101011, 6'b000000), "abort:ID");
        step(1'b0, e_madr(), "abort:MADR");
        step(1'b0, e_mem(1'b1), "abort:MWR");
        rst = 1'b1;
        step(1'b0, '0, "abort:rst");
        rst = 1'b0;
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, "after_abort_sub");

        for (int n = 0; n < 60; n++) begin
            ro = ops[$urandom_range(0, 7)];
            rf = fns[$urandom_range(0, 4)];
            if ($urandom_range(0, 5) == 0) ro = 6'($urandom);
            if ($urandom_range(0, 5) == 0) rf = 6'($urandom);
            run_instr(ro, rf, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
